// File: rtl/max10nios_command.sv
// max10nios_command
// Avalon-MM slave that hands a command byte to an external consumer over a
// four-phase valid/ack handshake. It reports completion and overrun through
// write-1-to-clear status flags. An optional interrupt is built in when the
// macro MAX10NIOS_COMMAND_IRQ_EN is defined. The default build leaves out
// both the irq port and IRQ_MASK.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   address     in   [1:0] word address (0 DATA, 1 STATUS, 2 IRQ_MASK, 3 rsvd)
//   chipselect  in   slave select, qualifies write_n
//   write_n     in   active-low write strobe
//   writedata   in   [31:0] write data
//   readdata    out  [31:0] registered read data, one-cycle latency
//   out_port    out  [7:0] command byte
//   out_valid   out  command valid
//   out_ack     in   consumer acknowledge (synchronous to clk)
//   irq         out  interrupt request (MAX10NIOS_COMMAND_IRQ_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no command pending; a DATA write is accepted
// VALID    | out_valid high, waiting for out_ack=1
// WAIT_LOW | out_valid low, waiting for out_ack to return 0

module max10nios_command (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port,
  output logic        out_valid,
  input  logic        out_ack
`ifdef MAX10NIOS_COMMAND_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_VALID    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic [31:0] rd_q, rd_d;

  logic wr_en, wr_data, wr_status;
  logic done_set, ovr_set, busy;
  logic unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_data   = wr_en & (address == 2'd0);
  assign wr_status = wr_en & (address == 2'd1);
  assign busy      = (state_q != ST_IDLE);

  // Upper write-data bits have no destination in this register map.
  assign unused_wdata = ^writedata[31:8];

  // Handshake FSM and command byte.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_data) begin
          data_d  = writedata[7:0];
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (out_ack) begin
          valid_d = 1'b0;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!out_ack) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A DATA write is judged against the state at the edge. A write that lands
  // on the cycle WAIT_LOW returns to IDLE is therefore still an overrun.
  assign ovr_set = wr_data & busy;

  // A flag being set wins over a same-cycle W1C clear.
  always_comb begin
    done_d = done_q;
    ovr_d  = ovr_q;
    if (wr_status && writedata[0]) done_d = 1'b0;
    if (wr_status && writedata[1]) ovr_d  = 1'b0;
    if (done_set) done_d = 1'b1;
    if (ovr_set)  ovr_d  = 1'b1;
  end

`ifdef MAX10NIOS_COMMAND_IRQ_EN
  logic [1:0] mask_q, mask_d;
  logic       irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && (address == 2'd2)) mask_d = writedata[1:0];
  end

  // Built from the registered flags, so irq follows them by one cycle.
  assign irq_d = |(mask_q & {ovr_q, done_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  // Read mux, sampled every cycle.
  always_comb begin
    rd_d = 32'd0;
    case (address)
      2'd0: rd_d = {24'd0, data_q};
      2'd1: rd_d = {29'd0, busy, ovr_q, done_q};
`ifdef MAX10NIOS_COMMAND_IRQ_EN
      2'd2: rd_d = {30'd0, mask_q};
`endif
      default: rd_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      rd_q    <= rd_d;
    end
  end

  assign readdata  = rd_q;
  assign out_port  = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_max10nios_command.sv
// Directed testbench for max10nios_command.
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled 1 time unit after an edge.
module tb_max10nios_command;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        out_valid;
  logic        out_ack;
`ifdef MAX10NIOS_COMMAND_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_errors = 0;

  max10nios_command dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ack    (out_ack)
`ifdef MAX10NIOS_COMMAND_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The write is committed at the edge inside the task.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  logic [31:0] rd;

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    out_ack    = 1'b0;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_port", {24'd0, out_port}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      bus_read(i[1:0], rd);
      check($sformatf("rst_read_a%0d", i), rd, 32'd0);
    end

    // Acknowledge while idle has no effect.
    out_ack = 1'b1;
    repeat (2) tick();
    out_ack = 1'b0;
    check("idle_ack_valid", {31'd0, out_valid}, 32'd0);
    bus_read(2'd1, rd);
    check("idle_ack_status", rd, 32'd0);

    // Basic handshake with byte 0x5A.
    bus_write(2'd0, 32'hFFFF_FF5A);
    check("h1_valid_rise", {31'd0, out_valid}, 32'd1);
    check("h1_port", {24'd0, out_port}, 32'h5A);
    bus_read(2'd1, rd);
    check("h1_status_busy", rd, 32'h4);
    tick();
    out_ack = 1'b1;
    tick();
    check("h1_valid_fall", {31'd0, out_valid}, 32'd0);
    check("h1_port_hold", {24'd0, out_port}, 32'h5A);
    tick();
    out_ack = 1'b0;
    tick();
    bus_read(2'd1, rd);
    check("h1_status_done", rd, 32'h1);
    bus_read(2'd0, rd);
    check("h1_data_rb", rd, 32'h5A);

    // Overrun while a command is still pending.
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'h11);
    bus_write(2'd0, 32'h22);
    check("ovr_port", {24'd0, out_port}, 32'h11);
    bus_read(2'd1, rd);
    check("ovr_status", rd, 32'h6);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, rd);
    check("ovr_cleared", rd, 32'h4);
    bus_read(2'd0, rd);
    check("ovr_data_rb", rd, 32'h11);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
    bus_read(2'd1, rd);
    check("ovr_done", rd, 32'h1);

    // A write on the edge where WAIT_LOW returns to IDLE is dropped.
    bus_write(2'd1, 32'h3);
    bus_write(2'd0, 32'h33);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    bus_write(2'd0, 32'h44);
    check("wl_port", {24'd0, out_port}, 32'h33);
    check("wl_valid", {31'd0, out_valid}, 32'd0);
    bus_read(2'd1, rd);
    check("wl_status", rd, 32'h3);

    // A W1C of DONE on the same edge that DONE is set: the set wins.
    bus_write(2'd1, 32'h3);
    bus_write(2'd0, 32'h55);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd);
    check("w1c_set_wins", rd, 32'h1);
    bus_write(2'd1, 32'h7);
    bus_read(2'd1, rd);
    check("w1c_clear", rd, 32'h0);

    // Asynchronous reset during VALID.
    bus_write(2'd0, 32'h66);
    check("ar_valid_pre", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid_async", {31'd0, out_valid}, 32'd0);
    check("ar_port_async", {24'd0, out_port}, 32'h0);
    #3;
    reset_n = 1'b1;
    tick();
    bus_read(2'd1, rd);
    check("ar_status", rd, 32'h0);
    bus_write(2'd0, 32'h77);
    check("ar_new_valid", {31'd0, out_valid}, 32'd1);
    check("ar_new_port", {24'd0, out_port}, 32'h77);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
    bus_read(2'd1, rd);
    check("ar_new_done", rd, 32'h1);
    bus_write(2'd1, 32'h3);

`ifdef MAX10NIOS_COMMAND_IRQ_EN
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd);
    check("irq_mask_rb", rd, 32'h1);
    check("irq_idle", {31'd0, irq}, 32'd0);
    bus_write(2'd0, 32'h88);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
    check("irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 32'h1);
    check("irq_hold", {31'd0, irq}, 32'd1);
    tick();
    check("irq_clear", {31'd0, irq}, 32'd0);
`else
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, rd);
    check("no_irq_a2", rd, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/max10nios_command.md
MAX10NIOS_COMMAND -- requirements
Module: max10nios_command

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 address  in  2  Avalon-MM slave word address.
REQ-005 chipselect  in  1  slave select; qualifies write_n.
REQ-006 write_n  in  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
REQ-007 writedata  in  32  write data; only the low bits listed below are used.
REQ-008 readdata  out  32  registered read data.
REQ-009 out_port  out  8  command byte to external consumer.
REQ-010 out_valid  out  1  command-valid strobe, four-phase handshake.
REQ-011 out_ack  in  1  consumer acknowledge, synchronous to clk.
REQ-012 irq  out  1  interrupt request; present only with MAX10NIOS_COMMAND_IRQ_EN.

Function
REQ-013 Register map: 0 DATA (R/W, bits 7:0); 1 STATUS (bit0 DONE W1C, bit1 OVERRUN W1C, bit2 BUSY RO); 2 IRQ_MASK (bits 1:0); 3 reserved.
REQ-014 readdata SHALL be updated every cycle from address; one-cycle latency; unused bits 0; address 3 reads 0.
REQ-015 FSM states: IDLE, VALID, WAIT_LOW.
REQ-016 IDLE: write to DATA loads out_port from writedata[7:0], sets out_valid=1, goes to VALID next cycle.
REQ-017 VALID: out_port and out_valid held stable; when out_ack=1, clear out_valid and go to WAIT_LOW.
REQ-018 WAIT_LOW: when out_ack=0, set DONE and go to IDLE.
REQ-019 BUSY = (state != IDLE).
REQ-020 A DATA write while state != IDLE at that edge SHALL be dropped, DATA unchanged, OVERRUN set; this includes the cycle where WAIT_LOW is leaving to IDLE.
REQ-021 out_ack=1 in IDLE SHALL be ignored.
REQ-022 STATUS write: a 1 in bit0/bit1 clears DONE/OVERRUN; bit2 ignored.
REQ-023 Set in the same cycle as W1C clear: set wins.
REQ-024 DATA readback SHALL return the last accepted byte (equal to out_port).

Reset
REQ-025 On reset_n=0: out_port=0, out_valid=0, readdata=0, state IDLE, DONE=0, OVERRUN=0, IRQ_MASK=0, irq=0, immediately and asynchronously.
REQ-026 Reset mid-handshake SHALL abort to IDLE with out_valid=0; no DONE is generated.
REQ-027 Deassertion SHALL take effect on the next rising clk edge.

Configuration
REQ-028 Macro MAX10NIOS_COMMAND_IRQ_EN defined: irq port exists; irq is a register = |(IRQ_MASK & {OVERRUN,DONE}), updated one cycle after the flags.
REQ-029 Macro undefined: irq port and IRQ_MASK absent; address 2 reads 0; writes to it are ignored.

Verification
REQ-030 Reset, then read all 4 addresses -> readdata=0 each, out_valid=0, out_port=0.
REQ-031 Write DATA=0x5A; ack high 3 cycles later, low 2 cycles after that -> out_valid rises next cycle and falls the cycle after ack is sampled; DONE=1 one cycle after ack is sampled low; STATUS reads 0x1.
REQ-032 Write DATA=0x11, then 0x22 while in VALID -> out_port stays 0x11; STATUS reads 0x6 (OVERRUN, BUSY); write STATUS=0x2 -> reads 0x4.
REQ-033 Write STATUS=0x1 in the same cycle DONE sets -> DONE reads 1.
REQ-034 Assert reset_n=0 during VALID -> out_valid=0 with no clock edge needed; after release STATUS=0 and a new write works.
REQ-035 With IRQ_EN: IRQ_MASK=0x1, complete handshake -> irq=1; clear DONE -> irq=0 one cycle later; without the macro, read address 2 -> 0.
